pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
Shares the single physical-memory port between the instruction cache and the data cache. Each cache's miss path (line fill or dirty writeback) presents a read or write request. The arbiter grants one requester at a time, latches that requester's command, drives pmem, and returns pmem_resp and read data to the granted cache only. It sits between the two cache_datapath/control pairs and physical memory.

Parameters:
PRIORITY_MODE, 0, 0 = round-robin on conflict; 1 = D-cache first, with a starvation guard
MAX_D_STREAK, 3, in mode 1, number of consecutive D grants allowed while I waits before I is forced

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
i_read  in  1  I-cache line read request
i_write  in  1  I-cache line write request
i_address  in  16  I-cache line address (lc3b_word)
i_wdata  in  128  I-cache write line
i_rdata  out  128  read line to I-cache
i_resp  out  1  I-cache transaction done
d_read  in  1  D-cache line read request
d_write  in  1  D-cache line write request
d_address  in  16  D-cache line address
d_wdata  in  128  D-cache write line
d_rdata  out  128  read line to D-cache
d_resp  out  1  D-cache transaction done
pmem_read  out  1  physical memory read strobe
pmem_write  out  1  physical memory write strobe
pmem_address  out  16  physical memory address
pmem_wdata  out  128  physical memory write line
pmem_rdata  in  128  physical memory read line
pmem_resp  in  1  physical memory done
grant_d  out  1  1 while D-cache owns pmem (debug/perf)

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D. On reset: IDLE; pmem_read, pmem_write, i_resp, d_resp and grant_d = 0; latched address/wdata/op = 0; last_grant = I; streak counter = 0.
- IDLE: a requester is active when its read|write is high. If one requester is active, grant it. If both are active:
  - mode 0: grant the one that is not last_grant.
  - mode 1: grant D unless streak == MAX_D_STREAK, in which case grant I.
- On grant, latch the grantee's address, wdata and op, then move to SERVE_x at the next edge. Write wins if read and write are both high.
- SERVE_x: pmem_read/pmem_write follow the latched op; pmem_address and pmem_wdata come from the latched registers and stay stable regardless of requester inputs. pmem_read/pmem_write are 0 in IDLE.
- Response: x_resp = pmem_resp while in SERVE_x. It is combinational, so it is high in the same cycle as pmem_resp, for exactly that cycle. The other requester's resp stays 0. i_rdata and d_rdata both carry pmem_rdata continuously; only the resp qualifies them.
- On pmem_resp in SERVE_x: go to IDLE and set last_grant = x.
- Streak counter (mode 1):
  - A completed D grant while i_read|i_write is high increments it, saturating at MAX_D_STREAK.
  - Any completed I grant clears it.
  - A D grant while I is idle clears it.
- Latency: request seen at edge 0 → strobe cycle 1 → resp in the pmem_resp cycle → IDLE next cycle. There is a one-cycle bubble between back-to-back transactions.
- Boundary conditions:
  - pmem_resp in IDLE is ignored; no resp is generated.
  - A requester dropping its request mid-transaction does not abort it: the transaction completes and resp is still pulsed.
  - Reset mid-transaction: strobes drop asynchronously and no resp is produced.
  - A new request from the just-served cache in the cycle after its resp is treated as a normal IDLE arbitration.
- grant_d = (state == SERVE_D).

Decomposition:
- Shared package lc3b_types: lc3b_cacheline ([127:0]) and the arbiter state enum (pmem_arb_state_t).
- One natural sub-module: arb_select. It is combinational; it takes the two active flags, last_grant, streak and the parameters, and returns the grant choice. The FSM, latches and counter stay in pmem_arbiter.

Test Plan:
- Lone D read of 0x1230, pmem_resp 3 cycles after strobe → pmem_read=1 and pmem_address=0x1230 from cycle 1; d_resp=1 in the resp cycle; d_rdata equals pmem_rdata; i_resp stays 0.
- Mode 0: I read 0x0040 and D write 0x8000 in the same cycle, last_grant=I after reset → D write first (pmem_write, pmem_wdata = d_wdata), then one IDLE cycle, then I read; resps in that order.
- Mode 1, MAX_D_STREAK=3: I held requesting while D issues 5 back-to-back reads → grant order D,D,D,I,D; streak reads 0 after the I grant.
- D changes d_address from 0x1230 to 0x5550 mid-SERVE_D → pmem_address stays 0x1230 until resp.
- reset pulsed 2 cycles into SERVE_I → pmem_read drops in the reset cycle with no i_resp. After reset, a lone I request re-arbitrates normally.
- pmem_resp glitched high in IDLE with no requests → no resp outputs and state stays IDLE.

Source files
------------

// File: rtl/lc3b_types.sv
// ---------------------------------------------------------------------------
// lc3b_types
// Shared types for the LC-3b memory hierarchy.
//   lc3b_word        : 16-bit machine word / line address
//   lc3b_cacheline   : one 128-bit cache line moved to and from physical memory
//   pmem_arb_state_t : state of the physical-memory arbiter
//   GRANT_I/GRANT_D  : encoding used when remembering which cache was served
//   streakWidth()    : bits needed to hold a D-streak count up to its maximum
// ---------------------------------------------------------------------------
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } pmem_arb_state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // One spare code point above the maximum keeps the width at least one bit,
  // even when the maximum streak is configured as zero.
  function automatic int streakWidth(input int maxStreak);
    return $clog2(maxStreak + 2);
  endfunction

endpackage

// File: rtl/pmem_arbiter_arb_select.sv
// ---------------------------------------------------------------------------
// arb_select
// Purely combinational grant decision for the physical-memory arbiter.
//   i_active_i     : I-cache is presenting a read or write
//   d_active_i     : D-cache is presenting a read or write
//   last_grant_i   : cache that completed the previous transaction (GRANT_I/D)
//   streak_i       : consecutive D grants completed while I was waiting
//   grant_valid_o  : at least one cache is requesting
//   grant_d_o      : 1 = grant the D-cache, 0 = grant the I-cache
// ---------------------------------------------------------------------------
module arb_select
  import lc3b_types::*;
#(
  parameter int PRIORITY_MODE = 0,
  parameter int MAX_D_STREAK  = 3,
  parameter int STREAK_W      = 3
) (
  input  logic                i_active_i,
  input  logic                d_active_i,
  input  logic                last_grant_i,
  input  logic [STREAK_W-1:0] streak_i,
  output logic                grant_valid_o,
  output logic                grant_d_o
);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_D_STREAK);

  // A lone requester always wins. On a conflict, round-robin mode hands the
  // port to whichever cache was not served last, while priority mode favours
  // the D-cache until it has been granted MAX_D_STREAK times in a row while
  // the I-cache waited, at which point the I-cache is forced through.
  always_comb begin
    grant_valid_o = i_active_i | d_active_i;
    grant_d_o     = 1'b0;
    if (d_active_i && !i_active_i) begin
      grant_d_o = 1'b1;
    end else if (d_active_i && i_active_i) begin
      if (PRIORITY_MODE == 0) begin
        grant_d_o = (last_grant_i == GRANT_I);
      end else begin
        grant_d_o = (streak_i != STREAK_LIMIT);
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// ---------------------------------------------------------------------------
// pmem_arbiter
// Shares the single physical-memory port between the I-cache and D-cache
// miss paths. One cache is granted at a time; its command is latched so the
// physical-memory side stays stable even if the cache changes its inputs.
//   clk, reset                : clock, asynchronous active-high reset
//   i_read/i_write/i_address  : I-cache line request
//   i_wdata                   : I-cache write line
//   i_rdata/i_resp            : read line and completion pulse to the I-cache
//   d_read/d_write/d_address  : D-cache line request
//   d_wdata                   : D-cache write line
//   d_rdata/d_resp            : read line and completion pulse to the D-cache
//   pmem_read/pmem_write      : physical-memory strobes
//   pmem_address/pmem_wdata   : latched command towards physical memory
//   pmem_rdata/pmem_resp      : physical-memory read line and done pulse
//   grant_d                   : high while the D-cache owns physical memory
// ---------------------------------------------------------------------------
module pmem_arbiter
  import lc3b_types::*;
#(
  parameter int PRIORITY_MODE = 0,
  parameter int MAX_D_STREAK  = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_read,
  input  logic          i_write,
  input  lc3b_word      i_address,
  input  lc3b_cacheline i_wdata,
  output lc3b_cacheline i_rdata,
  output logic          i_resp,
  input  logic          d_read,
  input  logic          d_write,
  input  lc3b_word      d_address,
  input  lc3b_cacheline d_wdata,
  output lc3b_cacheline d_rdata,
  output logic          d_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_cacheline pmem_wdata,
  input  lc3b_cacheline pmem_rdata,
  input  logic          pmem_resp,
  output logic          grant_d
);

  localparam int STREAK_W = streakWidth(MAX_D_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_D_STREAK);

  pmem_arb_state_t     state_q, state_d;
  lc3b_word            addr_q, addr_d;
  lc3b_cacheline       wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                last_grant_q, last_grant_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic iActive;
  logic dActive;
  logic grantValid;
  logic grantD;
  logic serving;

  assign iActive = i_read | i_write;
  assign dActive = d_read | d_write;

  arb_select #(
    .PRIORITY_MODE (PRIORITY_MODE),
    .MAX_D_STREAK  (MAX_D_STREAK),
    .STREAK_W      (STREAK_W)
  ) u_arb_select (
    .i_active_i    (iActive),
    .d_active_i    (dActive),
    .last_grant_i  (last_grant_q),
    .streak_i      (streak_q),
    .grant_valid_o (grantValid),
    .grant_d_o     (grantD)
  );

  // Next-state logic. Arbitration only happens in IDLE; once a cache is
  // granted, its command is captured here and the transaction runs to
  // completion regardless of what the cache does with its own inputs. When
  // read and write are both raised, the write is the one carried out.
  // The D-streak only moves in priority mode: a D completion while the
  // I-cache is still asking extends it (saturating), a D completion with the
  // I-cache quiet resets it, and any I completion resets it.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    last_grant_d = last_grant_q;
    streak_d     = streak_q;

    case (state_q)
      ARB_IDLE: begin
        if (grantValid) begin
          if (grantD) begin
            addr_d  = d_address;
            wdata_d = d_wdata;
            write_d = d_write;
            state_d = ARB_SERVE_D;
          end else begin
            addr_d  = i_address;
            wdata_d = i_wdata;
            write_d = i_write;
            state_d = ARB_SERVE_I;
          end
        end
      end

      ARB_SERVE_I: begin
        if (pmem_resp) begin
          state_d      = ARB_IDLE;
          last_grant_d = GRANT_I;
          if (PRIORITY_MODE != 0) begin
            streak_d = '0;
          end
        end
      end

      ARB_SERVE_D: begin
        if (pmem_resp) begin
          state_d      = ARB_IDLE;
          last_grant_d = GRANT_D;
          if (PRIORITY_MODE != 0) begin
            if (iActive) begin
              if (streak_q != STREAK_LIMIT) begin
                streak_d = streak_q + STREAK_W'(1);
              end
            end else begin
              streak_d = '0;
            end
          end
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and latched command registers. Reset is asynchronous so that the
  // memory strobes fall immediately, even in the middle of a transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      last_grant_q <= GRANT_I;
      streak_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      last_grant_q <= last_grant_d;
      streak_q     <= streak_d;
    end
  end

  // Physical-memory side is driven purely from the latched command, so it
  // is immune to requester input changes. Responses are combinational and
  // steered only to the cache that currently owns the port; both caches see
  // the read line at all times and rely on their resp to qualify it.
  always_comb begin
    serving      = (state_q != ARB_IDLE);
    pmem_read    = serving & ~write_q;
    pmem_write   = serving & write_q;
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
    i_resp       = (state_q == ARB_SERVE_I) & pmem_resp;
    d_resp       = (state_q == ARB_SERVE_D) & pmem_resp;
    i_rdata      = pmem_rdata;
    d_rdata      = pmem_rdata;
    grant_d      = (state_q == ARB_SERVE_D);
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pmem_arbiter
// Drives a round-robin instance (index 0) and a D-priority instance (index 1)
// with the same cache-side traffic and compares both against a transaction-
// level model of who owns memory, what command was captured and how the
// grant history evolves. Directed sequences pin the model with literal
// expectations before a long randomized run.
// ---------------------------------------------------------------------------
module tb_pmem_arbiter;

  localparam int MAX_STREAK = 3;

  logic         clk;
  logic         reset;
  logic         iRead, iWrite, dRead, dWrite;
  logic [15:0]  iAddress, dAddress;
  logic [127:0] iWdata, dWdata;

  logic [127:0] pmemRdata   [2];
  logic         pmemResp    [2];
  logic [127:0] iRdata      [2];
  logic [127:0] dRdata      [2];
  logic [127:0] pmemWdata   [2];
  logic [15:0]  pmemAddress [2];
  logic         iResp       [2];
  logic         dResp       [2];
  logic         pmemRead    [2];
  logic         pmemWrite   [2];
  logic         grantD      [2];

  // Model: whether a transaction is in flight, who owns it, the command it
  // captured, who finished last, and the D streak (only meaningful for 1).
  bit           mBusy   [2];
  bit           mOwnerD [2];
  bit           mWrite  [2];
  logic [15:0]  mAddr   [2];
  logic [127:0] mWdata  [2];
  bit           mLastD  [2];
  int           mStreak [2];
  int           waitCnt [2];

  int checkCount = 0;
  int passCount  = 0;

  pmem_arbiter #(.PRIORITY_MODE(0), .MAX_D_STREAK(MAX_STREAK)) dutRr (
    .clk(clk), .reset(reset),
    .i_read(iRead), .i_write(iWrite), .i_address(iAddress), .i_wdata(iWdata),
    .i_rdata(iRdata[0]), .i_resp(iResp[0]),
    .d_read(dRead), .d_write(dWrite), .d_address(dAddress), .d_wdata(dWdata),
    .d_rdata(dRdata[0]), .d_resp(dResp[0]),
    .pmem_read(pmemRead[0]), .pmem_write(pmemWrite[0]),
    .pmem_address(pmemAddress[0]), .pmem_wdata(pmemWdata[0]),
    .pmem_rdata(pmemRdata[0]), .pmem_resp(pmemResp[0]),
    .grant_d(grantD[0])
  );

  pmem_arbiter #(.PRIORITY_MODE(1), .MAX_D_STREAK(MAX_STREAK)) dutPri (
    .clk(clk), .reset(reset),
    .i_read(iRead), .i_write(iWrite), .i_address(iAddress), .i_wdata(iWdata),
    .i_rdata(iRdata[1]), .i_resp(iResp[1]),
    .d_read(dRead), .d_write(dWrite), .d_address(dAddress), .d_wdata(dWdata),
    .d_rdata(dRdata[1]), .d_resp(dResp[1]),
    .pmem_read(pmemRead[1]), .pmem_write(pmemWrite[1]),
    .pmem_address(pmemAddress[1]), .pmem_wdata(pmemWdata[1]),
    .pmem_rdata(pmemRdata[1]), .pmem_resp(pmemResp[1]),
    .grant_d(grantD[1])
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkBit(input string name, input int k, input logic act, input logic exp);
    checkCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s[%0d] at %0t: got %b, expected %b", name, k, $time, act, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic checkVec(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s[%0d] at %0t: got %h, expected %h", name, k, $time, act, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic modelReset(input int k);
    mBusy[k]   = 1'b0;
    mOwnerD[k] = 1'b0;
    mWrite[k]  = 1'b0;
    mAddr[k]   = '0;
    mWdata[k]  = '0;
    mLastD[k]  = 1'b0;
    mStreak[k] = 0;
    waitCnt[k] = 0;
  endtask

  // Who gets the port: -1 nobody, 0 the I-cache, 1 the D-cache.
  function automatic int pickOwner(input int k, input bit iAct, input bit dAct);
    if (!iAct && !dAct) return -1;
    if (!dAct) return 0;
    if (!iAct) return 1;
    if (k == 0) return mLastD[k] ? 0 : 1;
    return (mStreak[k] >= MAX_STREAK) ? 0 : 1;
  endfunction

  // Applies one rising edge to the model using the inputs the bench drove.
  task automatic modelAdvance();
    int owner;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        modelReset(k);
      end else if (!mBusy[k]) begin
        owner = pickOwner(k, iRead | iWrite, dRead | dWrite);
        if (owner >= 0) begin
          mBusy[k]   = 1'b1;
          mOwnerD[k] = (owner == 1);
          mAddr[k]   = (owner == 1) ? dAddress : iAddress;
          mWdata[k]  = (owner == 1) ? dWdata : iWdata;
          mWrite[k]  = (owner == 1) ? dWrite : iWrite;
          waitCnt[k] = $urandom_range(0, 3);
        end
      end else if (pmemResp[k]) begin
        mBusy[k]  = 1'b0;
        mLastD[k] = mOwnerD[k];
        if (k == 1) begin
          if (mOwnerD[k] && (iRead | iWrite)) begin
            mStreak[k] = (mStreak[k] + 1 > MAX_STREAK) ? MAX_STREAK : mStreak[k] + 1;
          end else begin
            mStreak[k] = 0;
          end
        end
      end
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  task automatic modelCompare();
    for (int k = 0; k < 2; k++) begin
      checkBit("pmem_read", k, pmemRead[k], mBusy[k] && !mWrite[k]);
      checkBit("pmem_write", k, pmemWrite[k], mBusy[k] && mWrite[k]);
      checkBit("grant_d", k, grantD[k], mBusy[k] && mOwnerD[k]);
      checkBit("i_resp", k, iResp[k], mBusy[k] && !mOwnerD[k] && pmemResp[k]);
      checkBit("d_resp", k, dResp[k], mBusy[k] && mOwnerD[k] && pmemResp[k]);
      checkVec("i_rdata", k, iRdata[k], pmemRdata[k]);
      checkVec("d_rdata", k, dRdata[k], pmemRdata[k]);
      if (mBusy[k]) begin
        checkVec("pmem_address", k, 128'(pmemAddress[k]), 128'(mAddr[k]));
        checkVec("pmem_wdata", k, pmemWdata[k], mWdata[k]);
      end
    end
  endtask

  task automatic settle();
    #1;
    modelCompare();
  endtask

  task automatic advance();
    @(posedge clk);
    modelAdvance();
    @(negedge clk);
  endtask

  task automatic setResp(input logic v);
    pmemResp[0] = v;
    pmemResp[1] = v;
  endtask

  task automatic idleInputs();
    iRead = 1'b0; iWrite = 1'b0; dRead = 1'b0; dWrite = 1'b0;
    setResp(1'b0);
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1'b1;
    advance();
    reset = 1'b0;
  endtask

  // Randomized cache and memory behaviour for one cycle. Caches mostly hold
  // their request, which also exercises mid-transaction drops and address
  // changes; memory answers owned transactions after a random delay and
  // occasionally glitches pmem_resp while nobody owns the port.
  task automatic applyStimulus();
    reset = ($urandom_range(0, 399) == 0);
    if (reset) begin
      modelReset(0);
      modelReset(1);
    end
    if ($urandom_range(0, 3) == 0) begin
      iRead    = $urandom_range(0, 1);
      iWrite   = ($urandom_range(0, 3) == 0);
      iAddress = 16'($urandom);
      iWdata   = {$urandom, $urandom, $urandom, $urandom};
    end
    if ($urandom_range(0, 3) == 0) begin
      dRead    = $urandom_range(0, 1);
      dWrite   = ($urandom_range(0, 2) == 0);
      dAddress = 16'($urandom);
      dWdata   = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int k = 0; k < 2; k++) begin
      pmemRdata[k] = {$urandom, $urandom, $urandom, $urandom};
      if (mBusy[k]) begin
        if (waitCnt[k] == 0) begin
          pmemResp[k] = 1'b1;
        end else begin
          pmemResp[k] = 1'b0;
          waitCnt[k]  = waitCnt[k] - 1;
        end
      end else begin
        pmemResp[k] = ($urandom_range(0, 15) == 0);
      end
    end
  endtask

  // Literal expectations used by the directed sequences.
  task automatic checkOutput(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
    checkVec({name, " lit"}, k, act, exp);
  endtask

  initial begin
    logic [127:0] rdataA;
    logic [127:0] wdataB;
    bit expRr  [8];
    bit expPri [8];
    expRr  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    expPri = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    rdataA = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F1E_2D3C;
    wdataB = 128'hA5A5_5A5A_0000_FFFF_1357_9BDF_2468_ACE0;

    reset = 1'b1;
    iAddress = '0; dAddress = '0; iWdata = '0; dWdata = '0;
    idleInputs();
    pmemRdata[0] = '0; pmemRdata[1] = '0;
    modelReset(0);
    modelReset(1);

    // Reset state, with pmem_resp raised to show it cannot leak through.
    @(negedge clk);
    setResp(1'b1);
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("reset pmem_read", k, 128'(pmemRead[k]), 128'(0));
      checkOutput("reset pmem_write", k, 128'(pmemWrite[k]), 128'(0));
      checkOutput("reset grant_d", k, 128'(grantD[k]), 128'(0));
      checkOutput("reset i_resp", k, 128'(iResp[k]), 128'(0));
      checkOutput("reset d_resp", k, 128'(dResp[k]), 128'(0));
    end
    reset = 1'b0;
    setResp(1'b0);
    advance();

    // Lone D read of 0x1230; address changes mid-transaction; resp 3 cycles
    // after the strobe first appears.
    $display("[TB] lone D read");
    dRead = 1'b1; dAddress = 16'h1230;
    settle(); advance();
    settle();
    for (int k = 0; k < 2; k++) begin
      checkOutput("d1 pmem_read", k, 128'(pmemRead[k]), 128'(1));
      checkOutput("d1 pmem_address", k, 128'(pmemAddress[k]), 128'(16'h1230));
    end
    advance();
    dAddress = 16'h5550;
    settle();
    for (int k = 0; k < 2; k++) begin
      checkOutput("d1 held address", k, 128'(pmemAddress[k]), 128'(16'h1230));
    end
    advance();
    settle(); advance();
    setResp(1'b1);
    pmemRdata[0] = rdataA; pmemRdata[1] = rdataA;
    settle();
    for (int k = 0; k < 2; k++) begin
      checkOutput("d1 d_resp", k, 128'(dResp[k]), 128'(1));
      checkOutput("d1 d_rdata", k, dRdata[k], rdataA);
      checkOutput("d1 i_resp", k, 128'(iResp[k]), 128'(0));
    end
    advance();
    dRead = 1'b0; setResp(1'b0);
    settle();
    for (int k = 0; k < 2; k++) begin
      checkOutput("d1 back idle", k, 128'(pmemRead[k]), 128'(0));
    end
    advance();

    // Simultaneous I read and D write right after reset.
    $display("[TB] simultaneous I read / D write");
    doReset();
    iRead = 1'b1; iAddress = 16'h0040;
    dWrite = 1'b1; dAddress = 16'h8000; dWdata = wdataB;
    settle(); advance();
    settle();
    checkOutput("c2 grant_d", 0, 128'(grantD[0]), 128'(1));
    checkOutput("c2 pmem_write", 0, 128'(pmemWrite[0]), 128'(1));
    checkOutput("c2 pmem_wdata", 0, pmemWdata[0], wdataB);
    checkOutput("c2 pmem_address", 0, 128'(pmemAddress[0]), 128'(16'h8000));
    advance();
    setResp(1'b1);
    settle();
    checkOutput("c2 d_resp", 0, 128'(dResp[0]), 128'(1));
    checkOutput("c2 i_resp early", 0, 128'(iResp[0]), 128'(0));
    advance();
    dWrite = 1'b0; setResp(1'b0);
    settle();
    checkOutput("c2 bubble read", 0, 128'(pmemRead[0]), 128'(0));
    checkOutput("c2 bubble write", 0, 128'(pmemWrite[0]), 128'(0));
    advance();
    setResp(1'b1);
    settle();
    checkOutput("c2 i pmem_read", 0, 128'(pmemRead[0]), 128'(1));
    checkOutput("c2 i pmem_address", 0, 128'(pmemAddress[0]), 128'(16'h0040));
    checkOutput("c2 i_resp", 0, 128'(iResp[0]), 128'(1));
    advance();
    iRead = 1'b0; setResp(1'b0);
    settle(); advance();

    // I waits while D streams reads: grant order per mode.
    $display("[TB] D streak vs waiting I");
    doReset();
    iRead = 1'b1; iAddress = 16'h0100;
    dRead = 1'b1; dAddress = 16'h2000;
    for (int n = 0; n < 16; n++) begin
      setResp(n[0]);
      settle();
      if (n[0]) begin
        checkOutput("order rr", 0, 128'(grantD[0]), 128'(expRr[n/2]));
        checkOutput("order pri", 1, 128'(grantD[1]), 128'(expPri[n/2]));
      end
      advance();
    end
    idleInputs();
    settle(); advance();

    // Reset two cycles into an I transaction, then normal re-arbitration.
    $display("[TB] reset mid-transaction");
    doReset();
    iRead = 1'b1; iAddress = 16'h0777;
    settle(); advance();
    settle(); advance();
    settle();
    checkOutput("r pmem_read before", 0, 128'(pmemRead[0]), 128'(1));
    #1;
    reset = 1'b1;
    setResp(1'b1);
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("r pmem_read dropped", k, 128'(pmemRead[k]), 128'(0));
      checkOutput("r no i_resp", k, 128'(iResp[k]), 128'(0));
    end
    advance();
    reset = 1'b0; setResp(1'b0);
    settle(); advance();
    setResp(1'b1);
    settle();
    for (int k = 0; k < 2; k++) begin
      checkOutput("r re-grant read", k, 128'(pmemRead[k]), 128'(1));
      checkOutput("r re-grant i_resp", k, 128'(iResp[k]), 128'(1));
      checkOutput("r re-grant address", k, 128'(pmemAddress[k]), 128'(16'h0777));
    end
    advance();
    idleInputs();
    settle(); advance();

    // pmem_resp glitch while idle.
    $display("[TB] idle pmem_resp glitch");
    setResp(1'b1);
    for (int n = 0; n < 2; n++) begin
      settle();
      for (int k = 0; k < 2; k++) begin
        checkOutput("g i_resp", k, 128'(iResp[k]), 128'(0));
        checkOutput("g d_resp", k, 128'(dResp[k]), 128'(0));
        checkOutput("g grant_d", k, 128'(grantD[k]), 128'(0));
      end
      advance();
    end
    setResp(1'b0); dRead = 1'b1; dAddress = 16'h3456;
    settle(); advance();
    setResp(1'b1);
    settle();
    for (int k = 0; k < 2; k++) begin
      checkOutput("g then d_resp", k, 128'(dResp[k]), 128'(1));
    end
    advance();
    idleInputs();
    settle(); advance();

    // Long randomized run against the model.
    $display("[TB] random traffic");
    for (int n = 0; n < 4000; n++) begin
      applyStimulus();
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
